// File: rtl/valid_lane_scheduler_pkg.sv
// Shared constants and FSM state type for the valid-lane scheduler.
package valid_lane_scheduler_pkg;
   localparam int unsigned VLS_LANES = 32;
   localparam int unsigned VLS_IDX_W = 5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } state_t;
endpackage

// File: rtl/rr_prio_enc32.sv
// Rotating priority encoder: first set bit of i_req scanning i_base, i_base+1, ... (mod LANES).
module rr_prio_enc32 #(
   parameter int unsigned LANES = 32,
   parameter int unsigned IDX_W = 5
) (
   input  logic [LANES-1:0] i_req,
   input  logic [IDX_W-1:0] i_base,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);
   logic [2*LANES-1:0] w_dbl;
   logic [LANES-1:0]   w_rot;
   logic [IDX_W-1:0]   w_off;
   logic               w_found;

   // Rotate right by base so bit 0 of w_rot is lane i_base, then LSB-first encode.
   assign w_dbl = {i_req, i_req} >> i_base;
   assign w_rot = w_dbl[LANES-1:0];

   always_comb begin
      w_off   = '0;
      w_found = 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (!w_found && w_rot[i]) begin
            w_off   = IDX_W'(i);
            w_found = 1'b1;
         end
      end
   end

   assign o_any = |i_req;
   assign o_idx = w_off + i_base;
endmodule

// File: rtl/valid_lane_scheduler.sv
// Issues each set lane of a captured valid mask to the lane engine, one per handshake,
// with a round-robin scan start carried across jobs.
module valid_lane_scheduler
   import valid_lane_scheduler_pkg::*;
#(
   parameter int unsigned LANES = VLS_LANES,
   parameter int unsigned IDX_W = VLS_IDX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [LANES-1:0] mask_i,
   output logic             busy_o,
   output logic             lane_valid_o,
   output logic [IDX_W-1:0] lane_idx_o,
   input  logic             lane_ready_i,
   output logic             done_o,
   output logic [IDX_W:0]   count_o
);
   state_t           r_state;
   logic [LANES-1:0] r_pending;
   logic [IDX_W-1:0] r_base;
   logic [IDX_W-1:0] r_rr_ptr;
   logic [IDX_W:0]   r_count;

   logic [IDX_W-1:0] w_idx;
   logic             w_any;
   logic [LANES-1:0] w_clr;
   logic             w_last;

   rr_prio_enc32 #(
      .LANES(LANES),
      .IDX_W(IDX_W)
   ) u_enc (
      .i_req (r_pending),
      .i_base(r_base),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   assign w_clr  = r_pending & ~(LANES'(1) << w_idx);
   assign w_last = ~|w_clr;

   // Outputs decode registered state only, so the offered index never follows inputs.
   assign lane_valid_o = (r_state == S_ISSUE) && w_any;
   assign lane_idx_o   = lane_valid_o ? w_idx : '0;
   assign busy_o       = (r_state != S_IDLE);
   assign done_o       = (r_state == S_DONE);
   assign count_o      = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_pending <= '0;
         r_base    <= '0;
         r_rr_ptr  <= '0;
         r_count   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_count <= '0;
                  if (|mask_i) begin
                     r_pending <= mask_i;
                     r_base    <= r_rr_ptr;
                     r_state   <= S_ISSUE;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_ISSUE: begin
               if (lane_ready_i) begin
                  r_pending <= w_clr;
                  r_count   <= r_count + (IDX_W+1)'(1);
                  r_rr_ptr  <= w_idx + IDX_W'(1);
                  if (w_last) r_state <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_valid_lane_scheduler.sv
// Self-checking bench: per-job expected lane order is computed from the mask and a model rr pointer.
module tb_valid_lane_scheduler;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic [31:0] mask_i;
   logic        busy_o;
   logic        lane_valid_o;
   logic [4:0]  lane_idx_o;
   logic        lane_ready_i;
   logic        done_o;
   logic [5:0]  count_o;

   int n_checks = 0;
   int n_fail   = 0;
   int m_rr     = 0;

   valid_lane_scheduler #(.LANES(32), .IDX_W(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .mask_i      (mask_i),
      .busy_o      (busy_o),
      .lane_valid_o(lane_valid_o),
      .lane_idx_o  (lane_idx_o),
      .lane_ready_i(lane_ready_i),
      .done_o      (done_o),
      .count_o     (count_o)
   );

   always #5 clk = ~clk;

   // mode: 0 ready always high, 1 random ready, 2 ready low for first 3 offered cycles
   task automatic run_job(input string name, input logic [31:0] mask, input int mode,
                          input bit inject);
      int  q[$];
      int  issued;
      int  offered;
      bit  done_seen;
      bit  rdy;
      logic [13:0] got, exp;
      for (int k = 0; k < 32; k++) begin
         int l;
         l = (m_rr + k) % 32;
         if (mask[l]) q.push_back(l);
      end
      @(posedge clk); #1;
      n_checks++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL %s idle_busy: got %b want 0", name, busy_o);
      end
      start_i = 1'b1; mask_i = mask; lane_ready_i = 1'b0;
      issued = 0; offered = 0; done_seen = 0;
      for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
         @(posedge clk); #1;
         start_i = (inject && cyc == 1);
         mask_i  = $urandom;
         got = {lane_valid_o, lane_idx_o, done_o, busy_o, count_o};
         if (q.size() > 0) begin
            exp = {1'b1, 5'(q[0]), 1'b0, 1'b1, 6'(issued)};
            case (mode)
               0:       rdy = 1'b1;
               1:       rdy = 1'($urandom_range(0, 1));
               default: rdy = (offered >= 3);
            endcase
            offered++;
            lane_ready_i = rdy;
            if (rdy) begin
               m_rr = (q[0] + 1) % 32;
               void'(q.pop_front());
               issued++;
            end
         end else begin
            exp = {1'b0, 5'd0, 1'b1, 1'b1, 6'(issued)};
            lane_ready_i = 1'($urandom_range(0, 1));
            done_seen = 1;
         end
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc%0d {valid,idx,done,busy,count}: got %b_%0d_%b_%b_%0d want %b_%0d_%b_%b_%0d",
                     name, cyc, got[13], got[12:8], got[7], got[6], got[5:0],
                     exp[13], exp[12:8], exp[7], exp[6], exp[5:0]);
         end
      end
      if (!done_seen) begin
         n_checks++; n_fail++;
         $display("FAIL %s timeout: got no done want done", name);
      end
      @(posedge clk); #1;
      start_i = 1'b0; lane_ready_i = 1'b0;
      got = {lane_valid_o, lane_idx_o, done_o, busy_o, count_o};
      exp = {1'b0, 5'd0, 1'b0, 1'b0, 6'(issued)};
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s after_done {valid,idx,done,busy,count}: got %b_%0d_%b_%b_%0d want 0_0_0_0_%0d",
                  name, got[13], got[12:8], got[7], got[6], got[5:0], issued);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start_i = 1'b0; mask_i = '0; lane_ready_i = 1'b0;
      #12;
      n_checks++;
      if ({busy_o, lane_valid_o, lane_idx_o, done_o, count_o} !== 14'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b valid=%b idx=%0d done=%b count=%0d want all 0",
                  busy_o, lane_valid_o, lane_idx_o, done_o, count_o);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      m_rr = 0;
   endtask

   task automatic test_single();       run_job("single",   32'h0000_0001, 0, 0); endtask
   task automatic test_wrap();         run_job("wrap",     32'h8000_0011, 0, 0); endtask
   task automatic test_backpressure(); run_job("backpr",   32'h0000_0006, 2, 0); endtask
   task automatic test_empty();        run_job("empty",    32'h0000_0000, 0, 0); endtask

   task automatic test_round_robin();
      run_job("rr_prep", 32'h0000_0010, 0, 0);
      run_job("rr_order", 32'h0000_0021, 0, 1);
   endtask

   task automatic test_reset_midjob();
      @(posedge clk); #1;
      start_i = 1'b1; mask_i = 32'h0000_0700; lane_ready_i = 1'b0;
      @(posedge clk); #1;
      start_i = 1'b0;
      n_checks++;
      if (lane_valid_o !== 1'b1 || lane_idx_o !== 5'(m_rr > 8 || m_rr < 8 ? 8 : 8)) begin
         n_fail++;
         $display("FAIL midrst_pre: got valid=%b idx=%0d want valid=1 idx=8", lane_valid_o, lane_idx_o);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy_o, lane_valid_o, done_o, count_o} !== 9'd0) begin
         n_fail++;
         $display("FAIL midrst_drop: got busy=%b valid=%b done=%b count=%0d want all 0",
                  busy_o, lane_valid_o, done_o, count_o);
      end
      m_rr = 0;
      @(posedge clk); #1; rst_n = 1'b1;
      run_job("post_rst", 32'h0000_8001, 0, 0);
   endtask

   task automatic test_random();
      for (int j = 0; j < 30; j++) begin
         logic [31:0] m;
         m = $urandom & $urandom;
         if ($urandom_range(0, 7) == 0) m = '0;
         if ($urandom_range(0, 7) == 0) m = '1;
         run_job("random", m, 1, 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_backpressure();
      test_empty();
      test_round_robin();
      test_reset_midjob();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
